// File: rtl/fht_io_sequencer_pkg.sv
// Shared constants, state encoding and bank-select helper for the FHT I/O sequencer.
package fht_io_sequencer_pkg;

  localparam int DEF_D_BIT   = 16;
  localparam int DEF_A_BIT   = 8;
  localparam int DEF_N_POINT = 1024;
  localparam int DEF_RD_LAT  = 1;
  localparam int NUM_BANKS   = 4;
  localparam int BANK_SIZE   = 2 ** DEF_A_BIT;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_START  = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4
  } seq_state_e;

  // One-hot write enable for the bank selected by the two low sample-index bits.
  function automatic logic [NUM_BANKS-1:0] bank_we(input logic [1:0] bank);
    return 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/fht_io_sequencer_serializer.sv
// Four-word holding register plus valid/ready output stage. A capture loads all four
// bank words at once; words then leave in bank order 0..3, one per accepted handshake.
module fht_seq_serializer #(
  parameter int D_BIT = 16
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  i_capture,
  input  logic [3:0][D_BIT-1:0] i_words,
  input  logic                  i_ready,
  output logic [D_BIT-1:0]      o_data,
  output logic                  o_valid,
  output logic                  o_done
);

  logic [3:0][D_BIT-1:0] r_hold;
  logic [1:0]            r_ptr;
  logic                  r_valid;
  logic                  w_xfer;

  assign w_xfer  = r_valid & i_ready;
  assign o_data  = r_hold[r_ptr];
  assign o_valid = r_valid;
  // Word 3 leaving tells the controller the holding register is free for the next group.
  assign o_done  = w_xfer & (r_ptr == 2'd3);

  // Load a fresh group, or step the word pointer on every accepted word.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_hold  <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_hold  <= i_words;
      r_ptr   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_ptr <= r_ptr + 2'd1;
      if (r_ptr == 2'd3) r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fht_io_sequencer.sv
// Frame controller around fht_top: scatters an input frame across the four RAM banks,
// starts the core, waits for a fresh RDY edge, then streams the four banks back out
// in natural order. One frame in flight at a time.
module fht_io_sequencer
  import fht_io_sequencer_pkg::*;
#(
  parameter int D_BIT   = DEF_D_BIT,
  parameter int A_BIT   = DEF_A_BIT,
  parameter int N_POINT = DEF_N_POINT,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iS_DATA,
  input  logic             iS_VALID,
  output logic             oS_READY,
  output logic [D_BIT-1:0] oM_DATA,
  output logic             oM_VALID,
  input  logic             iM_READY,
  output logic [3:0]       oFHT_WE,
  output logic [D_BIT-1:0] oFHT_DATA,
  output logic [A_BIT-1:0] oFHT_ADDR_WR,
  output logic [A_BIT-1:0] oFHT_ADDR_RD,
  input  logic [D_BIT-1:0] iFHT_DATA_0,
  input  logic [D_BIT-1:0] iFHT_DATA_1,
  input  logic [D_BIT-1:0] iFHT_DATA_2,
  input  logic [D_BIT-1:0] iFHT_DATA_3,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  output logic             oBUSY,
  output logic             oFRAME_DONE
);

  localparam int LD_W  = $clog2(N_POINT);
  localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(N_POINT - 1);
  localparam logic [A_BIT-1:0] GRP_LAST = '1;
  localparam logic [LAT_W-1:0] LAT_TC   = LAT_W'(RD_LAT);

  seq_state_e r_state, w_nxt;

  logic [LD_W-1:0]  r_ld_cnt;
  logic [A_BIT-1:0] r_grp;
  logic [LAT_W-1:0] r_lat;
  logic             r_fetch;
  logic             r_rdy_q;
  logic             r_s_ready;
  logic [3:0]       r_we;
  logic [D_BIT-1:0] r_wr_data;
  logic [A_BIT-1:0] r_wr_addr;
  logic             r_start;
  logic             r_frame_done;

  logic             w_s_acc;
  logic             w_ld_last;
  logic             w_rdy_rise;
  logic             w_capture;
  logic             w_word3;
  logic             w_frame_end;
  logic [3:0][D_BIT-1:0] w_words;

  // oS_READY is only ever high in LOAD, so it alone qualifies a sample accept.
  assign w_s_acc     = iS_VALID & r_s_ready;
  assign w_ld_last   = w_s_acc & (r_ld_cnt == LD_LAST);
  // RDY must rise while in WAIT; a level left high from an earlier run is ignored.
  assign w_rdy_rise  = iFHT_RDY & ~r_rdy_q;
  assign w_capture   = r_fetch & (r_lat == LAT_TC);
  assign w_frame_end = w_word3 & (r_grp == GRP_LAST);
  assign w_words     = {iFHT_DATA_3, iFHT_DATA_2, iFHT_DATA_1, iFHT_DATA_0};

  assign oS_READY     = r_s_ready;
  assign oFHT_WE      = r_we;
  assign oFHT_DATA    = r_wr_data;
  assign oFHT_ADDR_WR = r_wr_addr;
  assign oFHT_ADDR_RD = (r_state == S_UNLOAD) ? r_grp : '0;
  assign oFHT_START   = r_start;
  assign oBUSY        = (r_state != S_LOAD);
  assign oFRAME_DONE  = r_frame_done;

  // State register.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) r_state <= S_LOAD;
    else         r_state <= w_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_LOAD:   if (w_ld_last)   w_nxt = S_START;
      S_START:                   w_nxt = S_ARM;
      S_ARM:                     w_nxt = S_WAIT;
      S_WAIT:   if (w_rdy_rise)  w_nxt = S_UNLOAD;
      S_UNLOAD: if (w_frame_end) w_nxt = S_LOAD;
      default:                   w_nxt = S_LOAD;
    endcase
  end

  // Load path: register each accepted sample and issue its bank write one cycle later.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_s_ready <= 1'b0;
      r_we      <= '0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_ld_cnt  <= '0;
    end else begin
      r_s_ready <= (w_nxt == S_LOAD);
      r_we      <= w_s_acc ? bank_we(r_ld_cnt[1:0]) : 4'b0000;
      if (w_s_acc) begin
        r_wr_data <= iS_DATA;
        r_wr_addr <= A_BIT'(r_ld_cnt >> 2);
        r_ld_cnt  <= w_ld_last ? '0 : r_ld_cnt + 1'b1;
      end
    end
  end

  // Core handshake: registered start pulse, RDY history and end-of-frame pulse.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_start      <= 1'b0;
      r_rdy_q      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_start      <= (r_state == S_START);
      r_rdy_q      <= iFHT_RDY;
      r_frame_done <= w_frame_end;
    end
  end

  // Unload path: hold the group address for RD_LAT cycles, capture, then wait for
  // the serializer to drain word 3 before fetching the next group.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_grp   <= '0;
      r_lat   <= '0;
      r_fetch <= 1'b0;
    end else if (r_state == S_WAIT && w_rdy_rise) begin
      r_grp   <= '0;
      r_lat   <= '0;
      r_fetch <= 1'b1;
    end else if (w_capture) begin
      r_lat   <= '0;
      r_fetch <= 1'b0;
    end else if (r_fetch) begin
      r_lat <= r_lat + 1'b1;
    end else if (w_word3) begin
      if (w_frame_end) begin
        r_grp <= '0;
      end else begin
        r_grp   <= r_grp + 1'b1;
        r_fetch <= 1'b1;
      end
    end
  end

  fht_seq_serializer #(.D_BIT(D_BIT)) u_ser (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .i_capture (w_capture),
    .i_words   (w_words),
    .i_ready   (iM_READY),
    .o_data    (oM_DATA),
    .o_valid   (oM_VALID),
    .o_done    (w_word3)
  );

endmodule
